ita_step_sequencer: RTL and testbench
=====================================

ITA_STEP_SEQUENCER -- requirements
Module: ita_step_sequencer

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 4, max tiles issued but not yet completed.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have: rst_i  in  1  asynchronous active-high reset.
REQ-004 SHALL have: ctrl_i  in  ctrl_t  start, layer, activation, tile_s/e/p/f.
REQ-005 SHALL have: tile_valid_o  out  1 / tile_ready_i  in  1  tile-issue handshake.
REQ-006 SHALL have: step_o  out  step_e  step of issued tile.
REQ-007 SHALL have: tile_o_o, tile_m_o, tile_k_o  out  tile_t each  outer/middle/inner tile index.
REQ-008 SHALL have: first_k_o, last_k_o  out  1 each  first/last inner (reduction) tile.
REQ-009 SHALL have: requant_idx_o  out  idx_width(N_REQUANT_CONSTS)  index into eps_mult/right_shift/add arrays.
REQ-010 SHALL have: tile_done_i  in  1  one pulse per completed tile, in issue order.
REQ-011 SHALL have: busy_o  out  1; done_o  out  1  single-cycle pulse at layer end.

Function
REQ-012 SHALL use states IDLE, ISSUE, DRAIN.
REQ-013 In IDLE, ctrl_i.start=1 SHALL latch ctrl_i, load first step and go to ISSUE; tile_valid_o rises the following cycle.
REQ-014 start while not IDLE SHALL be ignored; latched config unchanged.
REQ-015 Step order: Attention Q,K,V,QK,AV,OW; SingleAttention Q,K,V,QK,AV; Feedforward F1,F2; Linear MatMul only.
REQ-016 Loop bounds (outer x middle x inner): Q/K/V s x p x e; QK s x s x p; AV s x p x s; OW s x e x p; F1 and MatMul s x f x e; F2 s x e x f.
REQ-017 Any tile field equal to 0 SHALL be treated as 1.
REQ-018 Indices SHALL advance inner-fastest, only on tile_valid_o && tile_ready_i; each wraps to 0 at bound-1.
REQ-019 first_k_o = (tile_k_o==0); last_k_o = (tile_k_o==inner bound-1).
REQ-020 requant_idx_o: Q0 K1 V2 QK3 AV4 OW5 F1 6 F2 7 MatMul 6.
REQ-021 step_o, indices, flags, requant_idx_o SHALL be stable while tile_valid_o=1 and tile_ready_i=0.
REQ-022 Outstanding counter: +1 on handshake, -1 on tile_done_i, unchanged when both same cycle.
REQ-023 tile_valid_o SHALL be 0 when outstanding==MaxOutstanding unless tile_done_i is 1 that cycle is NOT considered (registered decision).
REQ-024 tile_done_i with outstanding==0 SHALL be ignored (no underflow).
REQ-025 After last tile of a step handshakes, go to DRAIN; tile_valid_o=0.
REQ-026 DRAIN exits when outstanding reaches 0: next step -> ISSUE (valid next cycle); last step -> IDLE with done_o=1 that cycle.
REQ-027 busy_o=1 in ISSUE and DRAIN, 0 in IDLE.

Reset
REQ-028 rst_i SHALL force IDLE, all counters 0, step_o=Idle, tile_valid_o=0, busy_o=0, done_o=0, requant_idx_o=0, flags 0.
REQ-029 rst_i mid-layer SHALL abort with no done_o; later tile_done_i pulses ignored.

Structure
REQ-030 ita_package SHALL receive seq_state_e (IDLE/ISSUE/DRAIN) and localparam MaxOutstanding default.
REQ-031 Three-level nested index counter SHALL be a sub-module ita_tile_iter (bounds, advance, wrap indices, last-tile flag).

Verification
REQ-032 Linear, tile_s=2,f=1,e=3, ready=1, immediate done: 6 tiles, step MatMul, k 0,1,2 twice, requant_idx 6, one done_o.
REQ-033 Attention, all tiles=1: steps Q,K,V,QK,AV,OW once each, requant_idx 0..5, DRAIN between steps, done_o after OW completes.
REQ-034 Feedforward s=1,e=2,f=2, tile_done_i withheld: 4 F1 issues then valid low (MaxOutstanding=4); F2 only after 4 dones.
REQ-035 ready toggled randomly: outputs stable while stalled; no index skipped or repeated.
REQ-036 Start while busy and tile_e=0: start ignored; zero field yields bound 1.
REQ-037 rst_i asserted mid-QK: all outputs at reset values next cycle, no done_o; fresh start runs full layer.

Source files
------------

// File: rtl/ita_package.sv
// Shared types for the ITA step sequencer: layer/step/state enums, the
// control struct and the requant index width helper.
package ita_package;

    localparam int unsigned MaxOutstandingDefault = 4;
    localparam int unsigned N_REQUANT_CONSTS      = 8;

    // Width needed to index an array of n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned RequantIdxW = idx_width(N_REQUANT_CONSTS);

    typedef logic [7:0]             tile_t;
    typedef logic [RequantIdxW-1:0] requant_idx_t;

    typedef enum logic [1:0] {Attention, SingleAttention, Feedforward, Linear} layer_e;
    typedef enum logic [1:0] {Identity, Relu, Gelu} activation_e;
    typedef enum logic [3:0] {Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul} step_e;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_e;

    typedef struct packed {
        logic        start;
        layer_e      layer;
        activation_e activation;
        tile_t       tile_s;
        tile_t       tile_e;
        tile_t       tile_p;
        tile_t       tile_f;
    } ctrl_t;

endpackage

// File: rtl/ita_step_sequencer_if.sv
// Tile-issue bus between the step sequencer (master) and the datapath (slave).
// Handshake: a tile transfers on a rising clk edge where tile_valid_o and
// tile_ready_i are both 1; once tile_valid_o is raised, the tile payload
// (step, indices, flags, requant index, activation) holds until that
// transfer. tile_done_i is an independent one-cycle pulse per completed
// tile, returned in issue order.
interface ita_step_sequencer_if import ita_package::*; ;
    logic         tile_valid_o;
    logic         tile_ready_i;
    step_e        step_o;
    tile_t        tile_o_o;
    tile_t        tile_m_o;
    tile_t        tile_k_o;
    logic         first_k_o;
    logic         last_k_o;
    requant_idx_t requant_idx_o;
    activation_e  activation_o;
    logic         tile_done_i;

    modport master (
        output tile_valid_o, step_o, tile_o_o, tile_m_o, tile_k_o,
               first_k_o, last_k_o, requant_idx_o, activation_o,
        input  tile_ready_i, tile_done_i
    );

    modport slave (
        input  tile_valid_o, step_o, tile_o_o, tile_m_o, tile_k_o,
               first_k_o, last_k_o, requant_idx_o, activation_o,
        output tile_ready_i, tile_done_i
    );
endinterface

// File: rtl/ita_tile_iter.sv
// Three-level nested tile index counter (outer/middle/inner, inner fastest).
// Each index wraps to 0 after bound-1; last_tile flags the final tile.
module ita_tile_iter import ita_package::*; (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load,
    input  logic  advance,
    input  tile_t bound_outer,
    input  tile_t bound_mid,
    input  tile_t bound_inner,
    output tile_t idx_outer,
    output tile_t idx_mid,
    output tile_t idx_inner,
    output logic  last_inner,
    output logic  last_tile
);
    logic last_mid;
    logic last_outer;

    // Wrap points of each level; bounds are never zero here.
    always_comb begin
        last_inner = (idx_inner == bound_inner - tile_t'(1));
        last_mid   = (idx_mid   == bound_mid   - tile_t'(1));
        last_outer = (idx_outer == bound_outer - tile_t'(1));
        last_tile  = last_inner && last_mid && last_outer;
    end

    // Clear on load, otherwise odometer-style advance on each transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_outer <= '0;
            idx_mid   <= '0;
            idx_inner <= '0;
        end else if (load) begin
            idx_outer <= '0;
            idx_mid   <= '0;
            idx_inner <= '0;
        end else if (advance) begin
            if (!last_inner) begin
                idx_inner <= idx_inner + tile_t'(1);
            end else begin
                idx_inner <= '0;
                if (!last_mid) begin
                    idx_mid <= idx_mid + tile_t'(1);
                end else begin
                    idx_mid <= '0;
                    idx_outer <= last_outer ? '0 : idx_outer + tile_t'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ita_step_sequencer.sv
// Walks a layer's steps, issuing every tile of each step over a valid/ready
// bus, limiting tiles in flight and draining all of them between steps.
module ita_step_sequencer import ita_package::*; #(
    parameter int unsigned MaxOutstanding = MaxOutstandingDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  ctrl_t                       ctrl_i,
    ita_step_sequencer_if.master        tile_if,
    output logic                        busy_o,
    output logic                        done_o,
    output seq_state_e                  dbg_state_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    seq_state_e     state_q;
    step_e          step_q;
    layer_e         layer_q;
    activation_e    act_q;
    tile_t          s_q, e_q, p_q, f_q;
    logic [CntW-1:0] outstanding_q;
    logic           done_q;

    tile_t bound_outer, bound_mid, bound_inner;
    tile_t idx_outer, idx_mid, idx_inner;
    logic  last_inner, last_tile;
    logic  hs, dec, iter_load, drain_empty;
    step_e next_step;

    function automatic tile_t at_least_one(input tile_t v);
        return (v == '0) ? tile_t'(1) : v;
    endfunction

    function automatic step_e first_step(input layer_e l);
        case (l)
            Attention, SingleAttention: return Q;
            Feedforward:                return F1;
            default:                    return MatMul;
        endcase
    endfunction

    // Idle means the current step was the layer's last one.
    function automatic step_e follow_step(input layer_e l, input step_e s);
        case (s)
            Q:       return K;
            K:       return V;
            V:       return QK;
            QK:      return AV;
            AV:      return (l == Attention) ? OW : Idle;
            F1:      return F2;
            default: return Idle;
        endcase
    endfunction

    function automatic requant_idx_t requant_of(input step_e s);
        case (s)
            Q:       return requant_idx_t'(0);
            K:       return requant_idx_t'(1);
            V:       return requant_idx_t'(2);
            QK:      return requant_idx_t'(3);
            AV:      return requant_idx_t'(4);
            OW:      return requant_idx_t'(5);
            F1:      return requant_idx_t'(6);
            F2:      return requant_idx_t'(7);
            MatMul:  return requant_idx_t'(6);
            default: return requant_idx_t'(0);
        endcase
    endfunction

    // Loop bounds of the current step from the latched tile counts.
    always_comb begin
        bound_outer = at_least_one(s_q);
        bound_mid   = tile_t'(1);
        bound_inner = tile_t'(1);
        case (step_q)
            Q, K, V:     begin bound_mid = at_least_one(p_q); bound_inner = at_least_one(e_q); end
            QK:          begin bound_mid = at_least_one(s_q); bound_inner = at_least_one(p_q); end
            AV:          begin bound_mid = at_least_one(p_q); bound_inner = at_least_one(s_q); end
            OW:          begin bound_mid = at_least_one(e_q); bound_inner = at_least_one(p_q); end
            F1, MatMul:  begin bound_mid = at_least_one(f_q); bound_inner = at_least_one(e_q); end
            F2:          begin bound_mid = at_least_one(e_q); bound_inner = at_least_one(f_q); end
            default:     begin bound_mid = tile_t'(1);        bound_inner = tile_t'(1);        end
        endcase
    end

    // Valid depends only on registered state; a same-cycle done does not free a slot.
    assign tile_if.tile_valid_o = (state_q == ISSUE) && (outstanding_q != CntW'(MaxOutstanding));
    assign hs          = tile_if.tile_valid_o && tile_if.tile_ready_i;
    assign dec         = tile_if.tile_done_i && (outstanding_q != '0);
    assign drain_empty = (state_q == DRAIN) && (outstanding_q == '0);
    assign next_step   = follow_step(layer_q, step_q);
    assign iter_load   = ((state_q == IDLE) && ctrl_i.start) || drain_empty;

    ita_tile_iter u_iter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load        (iter_load),
        .advance     (hs),
        .bound_outer (bound_outer),
        .bound_mid   (bound_mid),
        .bound_inner (bound_inner),
        .idx_outer   (idx_outer),
        .idx_mid     (idx_mid),
        .idx_inner   (idx_inner),
        .last_inner  (last_inner),
        .last_tile   (last_tile)
    );

    // Sequencer FSM: latch config, issue a step, drain it, move on or finish.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            step_q  <= Idle;
            layer_q <= Attention;
            act_q   <= Identity;
            s_q     <= '0;
            e_q     <= '0;
            p_q     <= '0;
            f_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ctrl_i.start) begin
                        layer_q <= ctrl_i.layer;
                        act_q   <= ctrl_i.activation;
                        s_q     <= ctrl_i.tile_s;
                        e_q     <= ctrl_i.tile_e;
                        p_q     <= ctrl_i.tile_p;
                        f_q     <= ctrl_i.tile_f;
                        step_q  <= first_step(ctrl_i.layer);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hs && last_tile) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        step_q <= next_step;
                        if (next_step == Idle) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tiles in flight: up on transfer, down on completion, never below zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
        end else if (hs && !dec) begin
            outstanding_q <= outstanding_q + CntW'(1);
        end else if (dec && !hs) begin
            outstanding_q <= outstanding_q - CntW'(1);
        end
    end

    assign tile_if.step_o        = step_q;
    assign tile_if.tile_o_o      = idx_outer;
    assign tile_if.tile_m_o      = idx_mid;
    assign tile_if.tile_k_o      = idx_inner;
    assign tile_if.first_k_o     = (state_q == ISSUE) && (idx_inner == '0);
    assign tile_if.last_k_o      = (state_q == ISSUE) && last_inner;
    assign tile_if.requant_idx_o = requant_of(step_q);
    assign tile_if.activation_o  = act_q;
    assign busy_o                = (state_q != IDLE);
    assign done_o                = done_q;
    assign dbg_state_o           = state_q;
endmodule

// File: tb/tb_ita_step_sequencer.sv
// Self-checking bench for ita_step_sequencer: a tile-list model built from
// the layer rules, one per-cycle driver/compare process, directed scenarios
// followed by randomized layers.
module tb_ita_step_sequencer;
    import ita_package::*;

    localparam int MAX_OUT = 4;

    typedef struct packed {
        step_e        step;
        tile_t        o;
        tile_t        m;
        tile_t        k;
        logic         first_k;
        logic         last_k;
        requant_idx_t rq;
        activation_e  act;
    } item_t;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_i;
    ctrl_t      ctrl_i;
    logic       busy_o;
    logic       done_o;
    seq_state_e dbg_state;

    always #5 clk = ~clk;

    ita_step_sequencer_if bus ();

    ita_step_sequencer #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ctrl_i      (ctrl_i),
        .tile_if     (bus),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    item_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          out_m = 0;
    int          done_cnt = 0;
    int          issued_cnt = 0;
    int          ready_prob = 100;
    int          done_prob = 100;
    bit          stray = 1'b0;
    bit          stall_prev = 1'b0;
    bit          saw_drain = 1'b0;
    logic [63:0] snap;
    step_e       prev_step = Idle;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic tile_t nz(input tile_t v);
        return (v == 0) ? tile_t'(1) : v;
    endfunction

    function automatic requant_idx_t rq_of(input step_e s);
        case (s)
            Q: return 0;  K: return 1;  V: return 2;  QK: return 3;  AV: return 4;
            OW: return 5; F1: return 6; F2: return 7; MatMul: return 6;
            default: return 0;
        endcase
    endfunction

    // Expand a layer into its full ordered tile list.
    task automatic push_layer(input ctrl_t c);
        step_e seq[$];
        int    ob, mb, kb;
        int    s, e, p, f;
        s = nz(c.tile_s); e = nz(c.tile_e); p = nz(c.tile_p); f = nz(c.tile_f);
        case (c.layer)
            Attention:       seq = '{Q, K, V, QK, AV, OW};
            SingleAttention: seq = '{Q, K, V, QK, AV};
            Feedforward:     seq = '{F1, F2};
            default:         seq = '{MatMul};
        endcase
        foreach (seq[i]) begin
            ob = s;
            case (seq[i])
                Q, K, V:    begin mb = p; kb = e; end
                QK:         begin mb = s; kb = p; end
                AV:         begin mb = p; kb = s; end
                OW:         begin mb = e; kb = p; end
                F2:         begin mb = e; kb = f; end
                default:    begin mb = f; kb = e; end
            endcase
            for (int oi = 0; oi < ob; oi++)
                for (int mi = 0; mi < mb; mi++)
                    for (int ki = 0; ki < kb; ki++)
                        exp_q.push_back('{step: seq[i], o: tile_t'(oi), m: tile_t'(mi),
                                          k: tile_t'(ki), first_k: (ki == 0),
                                          last_k: (ki == kb - 1), rq: rq_of(seq[i]),
                                          act: c.activation});
        end
    endtask

    function automatic item_t act_item();
        return '{step: bus.step_o, o: bus.tile_o_o, m: bus.tile_m_o, k: bus.tile_k_o,
                 first_k: bus.first_k_o, last_k: bus.last_k_o, rq: bus.requant_idx_o,
                 act: bus.activation_o};
    endfunction

    function automatic logic [63:0] snap_now();
        return 64'({bus.tile_valid_o, act_item()});
    endfunction

    // ---------------- driver + compare, once per cycle ----------------
    always @(negedge clk) begin : drive_and_compare
        logic  rdy, dn;
        item_t e;
        int    pre;
        if (rst_i) begin
            exp_q.delete();
            out_m = 0;
            stall_prev = 1'b0;
            issued_cnt = 0;
            prev_step = Idle;
            bus.tile_ready_i = 1'b0;
            bus.tile_done_i = stray;
        end else begin
            if (stall_prev) chk("stall_hold", snap_now(), snap);
            if (done_o) begin
                chk("done_drained", {61'b0, exp_q.size() == 0, out_m == 0, busy_o}, 64'b110);
                done_cnt++;
            end
            if (dbg_state == DRAIN) saw_drain = 1'b1;
            if (!busy_o) begin
                prev_step = Idle;
                issued_cnt = 0;
            end
            rdy = ($urandom_range(99) < ready_prob);
            dn  = stray || (out_m > 0 && $urandom_range(99) < done_prob);
            bus.tile_ready_i = rdy;
            bus.tile_done_i  = dn;
            if (bus.tile_valid_o) chk("valid_below_max", 64'(out_m < MAX_OUT), 1);
            stall_prev = bus.tile_valid_o && !rdy;
            snap = snap_now();
            pre = out_m;
            if (bus.tile_valid_o && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("tile_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tile", 64'(act_item()), 64'(e));
                    if (e.step != prev_step && prev_step != Idle)
                        chk("step_after_drain", {62'b0, pre == 0, saw_drain}, 64'b11);
                    prev_step = e.step;
                    saw_drain = 1'b0;
                    issued_cnt++;
                end
                out_m++;
            end
            if (dn && pre > 0) out_m--;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
    endtask

    task automatic start_layer(input ctrl_t c);
        @(negedge clk);
        ctrl_i = c;
        ctrl_i.start = 1'b1;
        @(negedge clk);
        ctrl_i.start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_step"},  64'(bus.step_o), 64'(Idle));
        chk({tag, "_valid"}, 64'(bus.tile_valid_o), 0);
        chk({tag, "_busy"},  64'(busy_o), 0);
        chk({tag, "_done"},  64'(done_o), 0);
        chk({tag, "_rq"},    64'(bus.requant_idx_o), 0);
        chk({tag, "_flags"}, 64'({bus.first_k_o, bus.last_k_o}), 0);
        chk({tag, "_idx"},   64'({bus.tile_o_o, bus.tile_m_o, bus.tile_k_o}), 0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic run_to_done(input string name, input int budget);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt != base), 1);
        if (done_cnt == base) begin
            apply_reset();
        end else begin
            repeat (3) @(negedge clk);
            chk({name, "_single_done"}, 64'(done_cnt - base), 1);
            chk({name, "_model_empty"}, 64'(exp_q.size()), 0);
            chk({name, "_idle"}, 64'(busy_o), 0);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        ctrl_t c, c2;
        int    base, n;
        rst_i = 1'b1;
        ctrl_i = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        @(posedge clk); #1 rst_i = 1'b0;

        // Linear 2x1x3, always ready, immediate completion.
        c = '0; c.layer = Linear; c.activation = Relu;
        c.tile_s = 2; c.tile_f = 1; c.tile_e = 3;
        push_layer(c);
        chk("m_lin_count", 64'(exp_q.size()), 6);
        chk("m_lin_k2", 64'(exp_q[2].k), 2);
        chk("m_lin_k3", 64'(exp_q[3].k), 0);
        chk("m_lin_o5", 64'(exp_q[5].o), 1);
        chk("m_lin_rq", 64'(exp_q[4].rq), 6);
        ready_prob = 100; done_prob = 100;
        start_layer(c);
        chk("lin_busy", 64'(busy_o), 1);
        run_to_done("linear", 2000);

        // Attention with all tiles 1: one tile per step.
        c = '0; c.layer = Attention; c.activation = Gelu;
        c.tile_s = 1; c.tile_e = 1; c.tile_p = 1; c.tile_f = 1;
        push_layer(c);
        chk("m_att_count", 64'(exp_q.size()), 6);
        chk("m_att_step3", 64'(exp_q[3].step), 64'(QK));
        chk("m_att_rq5", 64'(exp_q[5].rq), 5);
        start_layer(c);
        run_to_done("attention1", 2000);

        // Feedforward with completions withheld: in-flight limit, then F2.
        c = '0; c.layer = Feedforward;
        c.tile_s = 1; c.tile_e = 2; c.tile_f = 2;
        push_layer(c);
        chk("m_ff_count", 64'(exp_q.size()), 8);
        done_prob = 0;
        start_layer(c);
        repeat (20) @(negedge clk);
        chk("ff_issued_at_limit", 64'(issued_cnt), 4);
        chk("ff_valid_low", 64'(bus.tile_valid_o), 0);
        chk("ff_step_f1", 64'(bus.step_o), 64'(F1));
        done_prob = 100;
        run_to_done("feedforward", 2000);

        // Zero tile field and a start pulse while busy.
        c = '0; c.layer = Linear; c.tile_s = 1; c.tile_e = 0; c.tile_f = 2;
        push_layer(c);
        chk("m_zero_count", 64'(exp_q.size()), 2);
        chk("m_zero_lastk", 64'(exp_q[0].last_k), 1);
        ready_prob = 50; done_prob = 0;
        start_layer(c);
        repeat (2) @(negedge clk);
        chk("ignore_busy", 64'(busy_o), 1);
        c2 = '0; c2.layer = Attention; c2.tile_s = 3; c2.tile_e = 3; c2.tile_p = 3;
        start_layer(c2);
        done_prob = 100;
        run_to_done("zero_field", 2000);

        // Randomized layers with random ready/done pressure.
        for (int it = 0; it < 8; it++) begin
            c = '0;
            c.layer = layer_e'($urandom_range(0, 3));
            c.activation = activation_e'($urandom_range(0, 2));
            c.tile_s = tile_t'($urandom_range(0, 3));
            c.tile_e = tile_t'($urandom_range(0, 3));
            c.tile_p = tile_t'($urandom_range(0, 3));
            c.tile_f = tile_t'($urandom_range(0, 3));
            ready_prob = $urandom_range(30, 100);
            done_prob = $urandom_range(20, 100);
            push_layer(c);
            start_layer(c);
            run_to_done($sformatf("rand%0d", it), 6000);
        end

        // Reset in the middle of QK, stray completions, then a fresh layer.
        c = '0; c.layer = Attention; c.tile_s = 2; c.tile_e = 2; c.tile_p = 2;
        ready_prob = 100; done_prob = 100;
        push_layer(c);
        start_layer(c);
        n = 0;
        while (bus.step_o != QK && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("qk_reached", 64'(bus.step_o == QK), 1);
        base = done_cnt;
        @(posedge clk); #1 rst_i = 1'b1;
        @(negedge clk);
        check_reset("mid");
        @(posedge clk); #1 rst_i = 1'b0;
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_no_done", 64'(done_cnt - base), 0);
        chk("mid_idle", 64'(busy_o), 0);
        push_layer(c);
        done_prob = 0;
        start_layer(c);
        repeat (20) @(negedge clk);
        chk("fresh_issued_at_limit", 64'(issued_cnt), 4);
        done_prob = 100;
        run_to_done("fresh", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
